// File: rtl/instruction_encoder.sv
// RV32I field packer for the boot/test loader: turns decoded fields into
// instruction words, tags each with a running byte address, and buffers two.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   i_valid / o_ready         input field handshake
//   i_opcode, i_funct7/3      opcode and function fields
//   i_rs1, i_rs2, i_rd        register addresses
//   i_imm                     sign-extended, unshifted immediate (XLEN bits)
//   o_valid / i_ready         output word handshake
//   o_instr, o_addr           encoded word and its byte address
//   o_err                     one-cycle pulse: last accepted input was dropped
//   o_err_cnt                 saturating count of dropped inputs
module instruction_encoder #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [6:0]        i_opcode,
  input  logic [6:0]        i_funct7,
  input  logic [2:0]        i_funct3,
  input  logic [XLEN-1:0]   i_imm,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  input  logic [4:0]        i_rd,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [31:0]       o_instr,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_err,
  output logic [7:0]        o_err_cnt
);

  localparam logic [6:0] OpRInt    = 7'b0110011;
  localparam logic [6:0] OpIInt    = 7'b0010011;
  localparam logic [6:0] OpILoad   = 7'b0000011;
  localparam logic [6:0] OpIJump   = 7'b1100111;
  localparam logic [6:0] OpSStore  = 7'b0100011;
  localparam logic [6:0] OpSBranch = 7'b1100011;
  localparam logic [6:0] OpUImm    = 7'b0110111;
  localparam logic [6:0] OpUPc     = 7'b0010111;
  localparam logic [6:0] OpUJump   = 7'b1101111;

  // True when v equals the sign extension of its low n bits:
  // every bit from n-1 upward must match.
  function automatic logic sext_ok(
    input logic [XLEN-1:0] v,
    input int              n
  );
    logic signed [XLEN-1:0] t;
    t = $signed(v) >>> (n - 1);
    return (t == '0) || (&t);
  endfunction

  logic is_r;
  logic is_i;
  logic is_sh;
  logic is_s;
  logic is_b;
  logic is_u;
  logic is_j;

  always_comb begin
    is_r  = (i_opcode == OpRInt);
    is_sh = (i_opcode == OpIInt) &&
            (i_funct3[1:0] == 2'b01);
    is_i  = ((i_opcode == OpIInt) ||
             (i_opcode == OpILoad) ||
             (i_opcode == OpIJump)) && !is_sh;
    is_s  = (i_opcode == OpSStore);
    is_b  = (i_opcode == OpSBranch);
    is_u  = (i_opcode == OpUImm) ||
            (i_opcode == OpUPc);
    is_j  = (i_opcode == OpUJump);
  end

  logic [31:0] enc;
  logic        legal;

  always_comb begin
    enc   = '0;
    legal = 1'b0;
    unique case (1'b1)
      is_r: begin
        enc   = {i_funct7, i_rs2, i_rs1,
                 i_funct3, i_rd, i_opcode};
        legal = 1'b1;
      end
      is_sh: begin
        enc   = {i_funct7, i_imm[4:0], i_rs1,
                 i_funct3, i_rd, i_opcode};
        legal = ((i_imm >> 5) == '0);
      end
      is_i: begin
        enc   = {i_imm[11:0], i_rs1,
                 i_funct3, i_rd, i_opcode};
        legal = sext_ok(i_imm, 12);
      end
      is_s: begin
        enc   = {i_imm[11:5], i_rs2, i_rs1,
                 i_funct3, i_imm[4:0], i_opcode};
        legal = sext_ok(i_imm, 12);
      end
      is_b: begin
        enc   = {i_imm[12], i_imm[10:5], i_rs2,
                 i_rs1, i_funct3, i_imm[4:1],
                 i_imm[11], i_opcode};
        legal = sext_ok(i_imm, 13) && !i_imm[0];
      end
      is_u: begin
        enc   = {i_imm[31:12], i_rd, i_opcode};
        // For XLEN==32 the 32-bit sign check is trivially true.
        legal = (i_imm[11:0] == 12'h000) &&
                sext_ok(i_imm, 32);
      end
      is_j: begin
        enc   = {i_imm[20], i_imm[10:1],
                 i_imm[11], i_imm[19:12],
                 i_rd, i_opcode};
        legal = sext_ok(i_imm, 21) && !i_imm[0];
      end
      default: begin
        enc   = '0;
        legal = 1'b0;
      end
    endcase
  end

  logic [31:0]       instr_q [2];
  logic [ADDR_W-1:0] addr_q  [2];
  logic              wr_idx;
  logic              rd_idx;
  logic [1:0]        count;
  logic [ADDR_W-1:0] wr_addr;

  logic accept;
  logic push;
  logic pop;

  // Ready depends on registered occupancy only, so a full buffer
  // never accepts even when it is being drained the same cycle.
  assign o_ready = (count != 2'd2);
  assign o_valid = (count != 2'd0);
  assign accept  = i_valid && o_ready;
  assign push    = accept && legal;
  assign pop     = o_valid && i_ready;

  // An empty buffer shows the address the next word will take.
  assign o_instr = o_valid ? instr_q[rd_idx] : 32'h0;
  assign o_addr  = o_valid ? addr_q[rd_idx] : wr_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q[0] <= '0;
      instr_q[1] <= '0;
      addr_q[0]  <= '0;
      addr_q[1]  <= '0;
      wr_idx     <= 1'b0;
      rd_idx     <= 1'b0;
      count      <= 2'd0;
      wr_addr    <= BASE_ADDR;
      o_err      <= 1'b0;
      o_err_cnt  <= 8'd0;
    end else begin
      if (push) begin
        instr_q[wr_idx] <= enc;
        addr_q[wr_idx]  <= wr_addr;
        wr_idx          <= ~wr_idx;
        wr_addr         <= wr_addr + ADDR_W'(4);
      end
      if (pop) begin
        rd_idx <= ~rd_idx;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      o_err <= accept && !legal;
      if (accept && !legal &&
          (o_err_cnt != 8'hFF)) begin
        o_err_cnt <= o_err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder: queued expectations are
// compared in order as the encoder hands words downstream.
module tb_instruction_encoder;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [6:0]  i_opcode;
  logic [6:0]  i_funct7;
  logic [2:0]  i_funct3;
  logic [31:0] i_imm;
  logic [4:0]  i_rs1;
  logic [4:0]  i_rs2;
  logic [4:0]  i_rd;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_instr;
  logic [31:0] o_addr;
  logic        o_err;
  logic [7:0]  o_err_cnt;

  instruction_encoder #(
    .XLEN(32),
    .ADDR_W(32),
    .BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_opcode(i_opcode),
    .i_funct7(i_funct7),
    .i_funct3(i_funct3),
    .i_imm(i_imm),
    .i_rs1(i_rs1),
    .i_rs2(i_rs2),
    .i_rd(i_rd),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_instr(o_instr),
    .o_addr(o_addr),
    .o_err(o_err),
    .o_err_cnt(o_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          err_seen = 0;
  int          exp_errs = 0;
  logic [31:0] exp_addr;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (o_err) err_seen++;
      if (o_valid && i_ready) begin
        if (q.size() == 0) begin
          check("spurious_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("instr", o_instr, e.instr);
          check("addr", o_addr, e.addr);
        end
      end
    end
  end

  task automatic send(
    input logic [6:0]  op,
    input logic [6:0]  f7,
    input logic [2:0]  f3,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [4:0]  rd,
    input logic [31:0] imm,
    input bit          legal,
    input logic [31:0] exp
  );
    int n;
    i_opcode = op;
    i_funct7 = f7;
    i_funct3 = f3;
    i_rs1    = rs1;
    i_rs2    = rs2;
    i_rd     = rd;
    i_imm    = imm;
    i_valid  = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (o_ready) break;
      n++;
      if (n > 200) break;
    end
    if (n > 200) begin
      check("ready_timeout", 32'd0, 32'd1);
      i_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      if (legal) begin
        q.push_back({exp, exp_addr});
        exp_addr = exp_addr + 32'd4;
      end else begin
        exp_errs++;
      end
      check("err_pulse", {31'd0, o_err},
            {31'd0, !legal});
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain", q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  logic [31:0] hold_i;
  logic [31:0] hold_a;
  int          err_base;

  initial begin
    rst      = 1'b1;
    i_valid  = 1'b0;
    i_ready  = 1'b1;
    i_opcode = '0;
    i_funct7 = '0;
    i_funct3 = '0;
    i_imm    = '0;
    i_rs1    = '0;
    i_rs2    = '0;
    i_rd     = '0;
    exp_addr = BASE;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_ready", {31'd0, o_ready}, 32'd1);
    check("rst_instr", o_instr, 32'd0);
    check("rst_addr", o_addr, BASE);
    check("rst_errcnt", {24'd0, o_err_cnt}, 32'd0);

    // ADDI x1, x0, 5 visible right after the accepting edge
    send(7'h13, 7'h00, 3'b000, 5'd0, 5'd0, 5'd1,
         32'd5, 1'b1, 32'h0050_0093);
    check("lat_valid", {31'd0, o_valid}, 32'd1);
    drain();

    // ADD then SW
    send(7'h33, 7'h00, 3'b000, 5'd1, 5'd2, 5'd3,
         32'd0, 1'b1, 32'h0020_81B3);
    send(7'h23, 7'h00, 3'b010, 5'd1, 5'd2, 5'd0,
         32'd8, 1'b1, 32'h0020_A423);
    drain();

    // B/J/U formats, shifts, boundary immediates, ignored fields
    send(7'h63, 7'h00, 3'b000, 5'd1, 5'd2, 5'd0,
         -32'sd4, 1'b1, 32'hFE20_8EE3);
    send(7'h6F, 7'h00, 3'b000, 5'd0, 5'd0, 5'd1,
         32'd2048, 1'b1, 32'h0010_00EF);
    send(7'h37, 7'h00, 3'b000, 5'd0, 5'd0, 5'd5,
         32'h1234_5000, 1'b1, 32'h1234_52B7);
    send(7'h13, 7'h00, 3'b001, 5'd2, 5'd0, 5'd1,
         32'd3, 1'b1, 32'h0031_1093);
    send(7'h13, 7'h20, 3'b101, 5'd2, 5'd0, 5'd1,
         32'd3, 1'b1, 32'h4031_5093);
    send(7'h13, 7'h5A, 3'b000, 5'd0, 5'd31, 5'd1,
         32'hFFFF_F800, 1'b1, 32'h8000_0093);
    send(7'h37, 7'h00, 3'b000, 5'd0, 5'd0, 5'd0,
         32'hFFFF_F000, 1'b1, 32'hFFFF_F037);
    drain();

    // Illegal inputs are dropped, counted, address untouched
    hold_a   = o_addr;
    err_base = err_seen;
    send(7'h13, 7'h00, 3'b000, 5'd0, 5'd0, 5'd1,
         32'd2048, 1'b0, 32'h0);
    send(7'h63, 7'h00, 3'b000, 5'd1, 5'd2, 5'd0,
         32'd3, 1'b0, 32'h0);
    send(7'h7F, 7'h00, 3'b000, 5'd1, 5'd2, 5'd3,
         32'd0, 1'b0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("ill_pulses", err_seen - err_base, 32'd3);
    check("ill_errcnt", {24'd0, o_err_cnt}, 32'd3);
    check("ill_valid", {31'd0, o_valid}, 32'd0);
    check("ill_addr", o_addr, hold_a);
    check("ill_addr_model", o_addr, exp_addr);

    send(7'h13, 7'h00, 3'b001, 5'd0, 5'd0, 5'd1,
         32'd32, 1'b0, 32'h0);
    send(7'h17, 7'h00, 3'b000, 5'd0, 5'd0, 5'd1,
         32'h0000_1001, 1'b0, 32'h0);
    send(7'h6F, 7'h00, 3'b000, 5'd0, 5'd0, 5'd1,
         32'd5, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    check("errcnt_total", {24'd0, o_err_cnt},
          exp_errs);

    // Back-pressure: two buffered, third waits for space
    i_ready = 1'b0;
    send(7'h13, 7'h00, 3'b000, 5'd0, 5'd0, 5'd1,
         32'd1, 1'b1, 32'h0010_0093);
    send(7'h13, 7'h00, 3'b000, 5'd0, 5'd0, 5'd2,
         32'd2, 1'b1, 32'h0020_0113);
    check("full_ready", {31'd0, o_ready}, 32'd0);
    hold_i = o_instr;
    hold_a = o_addr;
    fork
      send(7'h13, 7'h00, 3'b000, 5'd0, 5'd0, 5'd3,
           32'd3, 1'b1, 32'h0030_0193);
      begin
        repeat (3) @(posedge clk);
        #1;
        check("hold_instr", o_instr, hold_i);
        check("hold_addr", o_addr, hold_a);
        check("hold_ready", {31'd0, o_ready}, 32'd0);
        i_ready = 1'b1;
      end
    join
    drain();

    // Reset with two words buffered
    i_ready = 1'b0;
    send(7'h13, 7'h00, 3'b000, 5'd0, 5'd0, 5'd4,
         32'd4, 1'b1, 32'h0040_0213);
    send(7'h13, 7'h00, 3'b000, 5'd0, 5'd0, 5'd5,
         32'd5, 1'b1, 32'h0050_0293);
    check("pre_rst_valid", {31'd0, o_valid}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    exp_addr = BASE;
    check("mid_rst_valid", {31'd0, o_valid}, 32'd0);
    check("mid_rst_addr", o_addr, BASE);
    check("mid_rst_errcnt", {24'd0, o_err_cnt}, 32'd0);
    check("mid_rst_ready", {31'd0, o_ready}, 32'd1);
    i_ready = 1'b1;
    send(7'h13, 7'h00, 3'b000, 5'd0, 5'd0, 5'd1,
         32'd5, 1'b1, 32'h0050_0093);
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
